// File: rtl/crc_engine_param.sv
// crc_engine_param
//   Multi-cycle CRC engine with a runtime-programmable polynomial, init value,
//   final XOR, input/output bit reflection and per-word byte count. It folds
//   BITS_PER_CYCLE message bits into the CRC register each clock. CRC state
//   persists across words until crc_clear, so multi-word messages chain.
//
// Ports:
//   CLK              rising-edge clock
//   RST              synchronous, active-high reset
//   crc_clear        soft clear: latches config, loads crc_init, aborts a word
//   crc_poly         generator polynomial, normal form, implicit top bit
//   crc_init         initial CRC register value
//   crc_xorout       final XOR value
//   crc_reflect_in   1 = each byte consumed LSB first
//   crc_reflect_out  1 = CRC bit-reversed before the final XOR
//   crc_start        single-cycle request to absorb crc_data_in (IDLE only)
//   crc_data_in      message word, byte 0 = bits [7:0], consumed first
//   crc_nbytes       valid bytes in the word, counted from byte 0
//   crc_data_out     finalised CRC, registered
//   crc_ready        high in IDLE
//   crc_done         one-cycle pulse when a word finishes
//
// Parameter legality: DATA_WIDTH a multiple of 8 in 8..64, CRC_WIDTH in
// 8..DATA_WIDTH, BITS_PER_CYCLE one of 1, 2, 4, 8.

module crc_engine_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int CRC_WIDTH      = 32,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              crc_clear,
    input  logic [CRC_WIDTH-1:0]              crc_poly,
    input  logic [CRC_WIDTH-1:0]              crc_init,
    input  logic [CRC_WIDTH-1:0]              crc_xorout,
    input  logic                              crc_reflect_in,
    input  logic                              crc_reflect_out,
    input  logic                              crc_start,
    input  logic [DATA_WIDTH-1:0]             crc_data_in,
    input  logic [$clog2(DATA_WIDTH/8):0]     crc_nbytes,
    output logic [CRC_WIDTH-1:0]              crc_data_out,
    output logic                              crc_ready,
    output logic                              crc_done
);

    localparam int NBYTES_MAX = DATA_WIDTH / 8;
    localparam int NB_W       = $clog2(NBYTES_MAX) + 1;
    localparam int CNT_W      = $clog2(DATA_WIDTH) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    logic [CRC_WIDTH-1:0]   crc_state;
    logic [CRC_WIDTH-1:0]   cfg_poly;
    logic [CRC_WIDTH-1:0]   cfg_xorout;
    logic                   cfg_refin;
    logic                   cfg_refout;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]       bit_cnt;

    logic [NB_W-1:0]        nbytes_eff;
    logic [CRC_WIDTH-1:0]   next_crc;

    function automatic logic [CRC_WIDTH-1:0] reverse_crc(input logic [CRC_WIDTH-1:0] v);
        logic [CRC_WIDTH-1:0] r;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            r[i] = v[CRC_WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] finalise(input logic [CRC_WIDTH-1:0] s,
                                                      input logic [CRC_WIDTH-1:0] xorout,
                                                      input logic               refout);
        return (refout ? reverse_crc(s) : s) ^ xorout;
    endfunction

    // Reorders the word so the first message bit sits at the MSB of the shift
    // register: byte 0 on top, and within each byte bit 7 first (or bit 0
    // first when reflecting). The fold then always consumes from the top.
    function automatic logic [DATA_WIDTH-1:0] order_word(input logic [DATA_WIDTH-1:0] d,
                                                         input logic                  refin);
        logic [DATA_WIDTH-1:0] o;
        for (int b = 0; b < NBYTES_MAX; b++) begin
            for (int i = 0; i < 8; i++) begin
                o[DATA_WIDTH-1-8*b-i] = refin ? d[8*b+i] : d[8*b+7-i];
            end
        end
        return o;
    endfunction

    // Unrolled MSB-first bit-serial CRC update; chunk[BITS_PER_CYCLE-1] is
    // the earliest bit.
    function automatic logic [CRC_WIDTH-1:0] fold(input logic [CRC_WIDTH-1:0]      s,
                                                  input logic [BITS_PER_CYCLE-1:0] chunk,
                                                  input logic [CRC_WIDTH-1:0]      poly);
        logic [CRC_WIDTH-1:0] r;
        logic                 fb;
        r = s;
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            fb = r[CRC_WIDTH-1] ^ chunk[i];
            r  = {r[CRC_WIDTH-2:0], 1'b0} ^ (fb ? poly : '0);
        end
        return r;
    endfunction

    assign nbytes_eff = (crc_nbytes > NB_W'(NBYTES_MAX)) ? NB_W'(NBYTES_MAX) : crc_nbytes;
    assign next_crc   = fold(crc_state, shreg[DATA_WIDTH-1 -: BITS_PER_CYCLE], cfg_poly);

    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; blocking assignments would make the result
    // depend on statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            crc_state    <= '0;
            cfg_poly     <= '0;
            cfg_xorout   <= '0;
            cfg_refin    <= 1'b0;
            cfg_refout   <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            crc_data_out <= '0;
            crc_ready    <= 1'b1;
            crc_done     <= 1'b0;
        end else if (crc_clear) begin
            // Config is taken straight from the inputs so the cleared output
            // reflects the new settings on the very next cycle.
            cfg_poly     <= crc_poly;
            cfg_xorout   <= crc_xorout;
            cfg_refin    <= crc_reflect_in;
            cfg_refout   <= crc_reflect_out;
            crc_state    <= crc_init;
            state        <= IDLE;
            bit_cnt      <= '0;
            crc_data_out <= finalise(crc_init, crc_xorout, crc_reflect_out);
            crc_ready    <= 1'b1;
            crc_done     <= 1'b0;
        end else begin
            crc_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (crc_start && (crc_nbytes != '0)) begin
                        shreg     <= order_word(crc_data_in, cfg_refin);
                        bit_cnt   <= CNT_W'({nbytes_eff, 3'b000});
                        state     <= BUSY;
                        crc_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    crc_state <= next_crc;
                    shreg     <= shreg << BITS_PER_CYCLE;
                    bit_cnt   <= bit_cnt - CNT_W'(BITS_PER_CYCLE);
                    if (bit_cnt == CNT_W'(BITS_PER_CYCLE)) begin
                        crc_data_out <= finalise(next_crc, cfg_xorout, cfg_refout);
                        crc_done     <= 1'b1;
                        crc_ready    <= 1'b1;
                        state        <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_engine_param.sv
// Self-checking bench for crc_engine_param. Instance a uses the default
// parameters (CRC-32, 8 bits/cycle); instance b is CRC_WIDTH=16 at
// 1 bit/cycle. Expected results are pushed into per-instance queues when a
// word is issued; a monitor pops and compares on every crc_done.

module tb_crc_engine_param;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST;

    logic        a_clear, a_refin, a_refout, a_start;
    logic [31:0] a_poly, a_init, a_xorout, a_data, a_out;
    logic [2:0]  a_nbytes;
    logic        a_ready, a_done;

    logic        b_clear, b_refin, b_refout, b_start;
    logic [15:0] b_poly, b_init, b_xorout, b_out;
    logic [31:0] b_data;
    logic [2:0]  b_nbytes;
    logic        b_ready, b_done;

    crc_engine_param dut_a (
        .CLK             (CLK),
        .RST             (RST),
        .crc_clear       (a_clear),
        .crc_poly        (a_poly),
        .crc_init        (a_init),
        .crc_xorout      (a_xorout),
        .crc_reflect_in  (a_refin),
        .crc_reflect_out (a_refout),
        .crc_start       (a_start),
        .crc_data_in     (a_data),
        .crc_nbytes      (a_nbytes),
        .crc_data_out    (a_out),
        .crc_ready       (a_ready),
        .crc_done        (a_done)
    );

    crc_engine_param #(
        .DATA_WIDTH     (32),
        .CRC_WIDTH      (16),
        .BITS_PER_CYCLE (1)
    ) dut_b (
        .CLK             (CLK),
        .RST             (RST),
        .crc_clear       (b_clear),
        .crc_poly        (b_poly),
        .crc_init        (b_init),
        .crc_xorout      (b_xorout),
        .crc_reflect_in  (b_refin),
        .crc_reflect_out (b_refout),
        .crc_start       (b_start),
        .crc_data_in     (b_data),
        .crc_nbytes      (b_nbytes),
        .crc_data_out    (b_out),
        .crc_ready       (b_ready),
        .crc_done        (b_done)
    );

    typedef struct {
        bit          chk;
        logic [31:0] val;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int n_vec      = 0;
    int n_fail     = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int accepted_a = 0;
    int accepted_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every crc_done pops one expected entry.
    always @(negedge CLK) begin
        if (a_done === 1'b1) begin : mon_a
            exp_t e;
            done_cnt_a++;
            check("a_ready_with_done", 32'(a_ready), 32'd1);
            if (exp_a.size() == 0) begin
                check("a_unexpected_done", 32'(exp_a.size()), 32'd1);
            end else begin
                e = exp_a.pop_front();
                if (e.chk) check("a_result", a_out, e.val);
            end
        end
        if (b_done === 1'b1) begin : mon_b
            exp_t e;
            done_cnt_b++;
            check("b_ready_with_done", 32'(b_ready), 32'd1);
            if (exp_b.size() == 0) begin
                check("b_unexpected_done", 32'(exp_b.size()), 32'd1);
            end else begin
                e = exp_b.pop_front();
                if (e.chk) check("b_result", 32'(b_out), e.val);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_start(input bit sel, input logic s, input logic [31:0] d,
                               input logic [2:0] nb);
        if (sel) begin
            b_start = s; b_data = d; b_nbytes = nb;
        end else begin
            a_start = s; a_data = d; a_nbytes = nb;
        end
    endtask

    task automatic do_clear(input bit sel, input bit with_start);
        if (sel) b_clear = 1'b1; else a_clear = 1'b1;
        if (with_start) drive_start(sel, 1'b1, 32'h34333231, 3'd4);
        tick();
        a_clear = 1'b0;
        b_clear = 1'b0;
        drive_start(sel, 1'b0, 32'h0, 3'd0);
    endtask

    // Issues one word, then waits (bounded) for crc_done and checks latency.
    // With poke set, a second crc_start is driven while the word is BUSY.
    task automatic send(input bit sel, input logic [31:0] data, input logic [2:0] nb,
                        input int exp_lat, input bit chk, input logic [31:0] exp_val,
                        input string name, input bit poke, output int lat);
        exp_t e;
        int   cyc;
        logic dn;
        logic rdy;
        e.chk = chk;
        e.val = exp_val;
        if (sel) begin
            exp_b.push_back(e); accepted_b++;
        end else begin
            exp_a.push_back(e); accepted_a++;
        end
        drive_start(sel, 1'b1, data, nb);
        tick();
        drive_start(sel, 1'b0, 32'h0, 3'd0);
        cyc = 0;
        while (cyc < 200) begin
            tick();
            cyc++;
            dn  = sel ? b_done : a_done;
            rdy = sel ? b_ready : a_ready;
            if (dn === 1'b1) break;
            if (cyc == 1) check({name, "_busy_ready"}, 32'(rdy), 32'd0);
            if (poke && cyc == 1) drive_start(sel, 1'b1, 32'hDEADBEEF, 3'd4);
            if (poke && cyc == 2) drive_start(sel, 1'b0, 32'h0, 3'd0);
        end
        check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        lat = cyc;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int l0, l1, l2, d0;
        RST = 1'b1;
        a_clear = 0; a_refin = 0; a_refout = 0; a_start = 0;
        a_poly = 0; a_init = 0; a_xorout = 0; a_data = 0; a_nbytes = 0;
        b_clear = 0; b_refin = 0; b_refout = 0; b_start = 0;
        b_poly = 0; b_init = 0; b_xorout = 0; b_data = 0; b_nbytes = 0;

        // Reset state.
        tick();
        tick();
        check("rst_a_out",   a_out, 32'h0);
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_a_done",  32'(a_done), 32'd0);
        check("rst_b_out",   32'(b_out), 32'h0);
        RST = 1'b0;

        // CRC-32 of "123456789".
        a_poly = 32'h04C11DB7; a_init = 32'hFFFFFFFF; a_xorout = 32'hFFFFFFFF;
        a_refin = 1'b1; a_refout = 1'b1;
        do_clear(0, 0);
        check("a_clear_out", a_out, 32'h00000000);
        send(0, 32'h34333231, 3'd4, 4, 0, 32'h0, "a_w0", 0, l0);
        send(0, 32'h38373635, 3'd4, 4, 0, 32'h0, "a_w1", 0, l1);
        send(0, 32'h00000039, 3'd1, 1, 1, 32'hCBF43926, "a_w2", 0, l2);
        check("a_crc32_out", a_out, 32'hCBF43926);
        check("a_busy_total", 32'(l0 + l1 + l2), 32'd9);

        // CRC-16/CCITT-FALSE of "123456789", one bit per cycle.
        b_poly = 16'h1021; b_init = 16'hFFFF; b_xorout = 16'h0000;
        b_refin = 1'b0; b_refout = 1'b0;
        do_clear(1, 0);
        check("b_clear_out", 32'(b_out), 32'h0000FFFF);
        send(1, 32'h34333231, 3'd4, 32, 0, 32'h0, "b_w0", 0, l0);
        send(1, 32'h38373635, 3'd4, 32, 0, 32'h0, "b_w1", 0, l1);
        send(1, 32'h00000039, 3'd1, 8, 1, 32'h000029B1, "b_w2", 0, l2);
        check("b_crc16_out", 32'(b_out), 32'h000029B1);

        // Start during BUSY, nbytes=0 in IDLE, nbytes clamped from 7 to 4.
        tick();
        d0 = done_cnt_a;
        do_clear(0, 0);
        send(0, 32'h34333231, 3'd4, 4, 0, 32'h0, "a_poke", 1, l0);
        drive_start(0, 1'b1, 32'h00000030, 3'd0);
        tick();
        drive_start(0, 1'b0, 32'h0, 3'd0);
        repeat (6) tick();
        check("a_nbytes0_ready", 32'(a_ready), 32'd1);
        check("a_nbytes0_no_done", 32'(done_cnt_a - d0), 32'd1);
        send(0, 32'h38373635, 3'd7, 4, 0, 32'h0, "a_clamp", 0, l1);
        send(0, 32'h00000039, 3'd1, 1, 1, 32'hCBF43926, "a_w2b", 0, l2);
        tick();
        check("a_ignore_out", a_out, 32'hCBF43926);
        check("a_ignore_done_cnt", 32'(done_cnt_a - d0), 32'd3);

        // crc_clear together with crc_start: start dropped.
        d0 = done_cnt_a;
        do_clear(0, 1);
        repeat (6) tick();
        check("a_clr_start_ready", 32'(a_ready), 32'd1);
        check("a_clr_start_out", a_out, 32'h00000000);
        check("a_clr_start_done", 32'(done_cnt_a - d0), 32'd0);

        // crc_clear mid-BUSY: word aborted, no crc_done.
        drive_start(0, 1'b1, 32'h34333231, 3'd4);
        tick();
        drive_start(0, 1'b0, 32'h0, 3'd0);
        tick();
        do_clear(0, 0);
        repeat (6) tick();
        check("a_abort_ready", 32'(a_ready), 32'd1);
        check("a_abort_out", a_out, 32'h00000000);
        check("a_abort_done", 32'(done_cnt_a - d0), 32'd0);

        // Config inputs changed without a clear have no effect.
        a_poly = 32'h1EDC6F41; a_xorout = 32'h0; a_refin = 1'b0; a_refout = 1'b0;
        a_init = 32'h0;
        send(0, 32'h34333231, 3'd4, 4, 0, 32'h0, "a_cfg_w0", 0, l0);
        send(0, 32'h38373635, 3'd4, 4, 0, 32'h0, "a_cfg_w1", 0, l1);
        send(0, 32'h00000039, 3'd1, 1, 1, 32'hCBF43926, "a_cfg_w2", 0, l2);
        check("a_cfg_out", a_out, 32'hCBF43926);

        // Reset held 2 cycles mid-BUSY.
        drive_start(0, 1'b1, 32'h34333231, 3'd4);
        tick();
        drive_start(0, 1'b0, 32'h0, 3'd0);
        tick();
        d0 = done_cnt_a;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        check("rst2_a_out",   a_out, 32'h0);
        check("rst2_a_ready", 32'(a_ready), 32'd1);
        check("rst2_a_done",  32'(a_done), 32'd0);
        repeat (6) tick();
        check("rst2_a_idle_ready", 32'(a_ready), 32'd1);
        check("rst2_a_no_done", 32'(done_cnt_a - d0), 32'd0);

        // Every accepted word produced exactly one crc_done.
        tick();
        check("a_done_total", 32'(done_cnt_a), 32'(accepted_a));
        check("b_done_total", 32'(done_cnt_b), 32'(accepted_b));
        check("a_queue_empty", 32'(exp_a.size()), 32'd0);
        check("b_queue_empty", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
